// File: rtl/wvb_occupancy_monitor.sv
// wvb_occupancy_monitor: per-channel waveform buffer occupancy, overflow, almost-full and high-water tracking
module wvb_occupancy_monitor #(
  parameter int P_N_CHAN    = 8,
  parameter int P_ADR_WIDTH = 12,
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [P_N_CHAN*P_ADR_WIDTH-1:0] wvb_wr_addr,
  input  logic [P_N_CHAN*P_ADR_WIDTH-1:0] wvb_stop_addr,
  input  logic [P_N_CHAN-1:0]             wvb_rddone,
  input  logic [P_N_CHAN-1:0]             hdr_full,
  input  logic [15:0]                     thresh_hi,
  input  logic [15:0]                     thresh_lo,
  input  logic [P_N_CHAN-1:0]             ovf_clr,
  input  logic [P_N_CHAN-1:0]             hwm_clr,
  output logic [P_N_CHAN-1:0]             overflow,
  output logic                            any_overflow,
  output logic [P_N_CHAN*16-1:0]          wvb_wused,
  output logic [P_N_CHAN-1:0]             almost_full,
  output logic [P_N_CHAN-1:0]             ovf_sticky,
  output logic [P_N_CHAN*P_CNT_WIDTH-1:0] ovf_cnt,
  output logic [P_N_CHAN*16-1:0]          wused_hwm
);
  localparam int A = P_ADR_WIDTH;
  localparam int C = P_CNT_WIDTH;
  assign any_overflow = |overflow;
  for (genvar c = 0; c < P_N_CHAN; c++) begin : g_chan
    logic [A-1:0]  w_wr, w_next_rd, r_last_rd, r_wr_q, r_wused_i;
    logic          r_full, r_rddone_q, r_ovf_q, r_af, r_sticky, w_edge, w_full_set;
    logic [C-1:0]  r_cnt;
    logic [15:0]   w_wused, r_hwm;
    assign w_wr       = wvb_wr_addr[c*A +: A];
    assign w_next_rd  = r_last_rd + 1'b1;
    assign overflow[c] = hdr_full[c] | (w_wr == r_last_rd);
    assign w_edge     = overflow[c] & ~r_ovf_q;
    // writer moved from last_rd onto next_rd: it wrapped over unread data
    assign w_full_set = (w_wr == w_next_rd) && (r_wr_q == r_last_rd);
    assign w_wused    = r_full ? 16'(1 << A) : 16'(r_wused_i);
    assign wvb_wused[c*16 +: 16] = w_wused;
    assign wused_hwm[c*16 +: 16] = r_hwm;
    assign ovf_cnt[c*C +: C]     = r_cnt;
    assign almost_full[c]        = r_af;
    assign ovf_sticky[c]         = r_sticky;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_last_rd  <= '1;
        r_wr_q     <= '0;
        r_wused_i  <= '0;
        r_rddone_q <= 1'b0;
        r_full     <= 1'b0;
        r_af       <= 1'b0;
        r_ovf_q    <= 1'b0;
        r_sticky   <= 1'b0;
        r_cnt      <= '0;
        r_hwm      <= '0;
      end else begin
        if (wvb_rddone[c]) r_last_rd <= wvb_stop_addr[c*A +: A];
        r_wr_q     <= w_wr;
        r_wused_i  <= w_wr - w_next_rd;
        r_rddone_q <= wvb_rddone[c];
        r_full     <= r_rddone_q ? 1'b0 : (r_full | w_full_set);
        r_af       <= (w_wused >= thresh_hi) ? 1'b1 : (w_wused < thresh_lo) ? 1'b0 : r_af;
        r_ovf_q    <= overflow[c];
        r_sticky   <= w_edge | (r_sticky & ~ovf_clr[c]);
        r_cnt      <= ovf_clr[c] ? C'(w_edge) : (w_edge && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
        r_hwm      <= hwm_clr[c] ? w_wused : (w_wused > r_hwm) ? w_wused : r_hwm;
      end
    end
  end
endmodule

// File: tb/tb_wvb_occupancy_monitor.sv
// tb_wvb_occupancy_monitor: scenario tasks with a queue of expected values popped at each DUT sample
module tb_wvb_occupancy_monitor;
  localparam int N = 4;
  localparam int A = 12;
  localparam int C = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [A-1:0] wr [N];
  logic [A-1:0] stop [N];
  logic [N*A-1:0] wvb_wr_addr, wvb_stop_addr;
  logic [N-1:0] wvb_rddone = '0, hdr_full = '0, ovf_clr = '0, hwm_clr = '0;
  logic [15:0] thresh_hi = 16'hFFFF, thresh_lo = 16'hFFFF;
  logic [N-1:0] overflow, almost_full, ovf_sticky;
  logic any_overflow;
  logic [N*16-1:0] wvb_wused, wused_hwm;
  logic [N*C-1:0] ovf_cnt;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign wvb_wr_addr[g*A +: A]   = wr[g];
    assign wvb_stop_addr[g*A +: A] = stop[g];
  end

  wvb_occupancy_monitor #(.P_N_CHAN(N), .P_ADR_WIDTH(A), .P_CNT_WIDTH(C)) dut (
    .clk(clk), .rst_n(rst_n), .wvb_wr_addr(wvb_wr_addr), .wvb_stop_addr(wvb_stop_addr),
    .wvb_rddone(wvb_rddone), .hdr_full(hdr_full), .thresh_hi(thresh_hi), .thresh_lo(thresh_lo),
    .ovf_clr(ovf_clr), .hwm_clr(hwm_clr), .overflow(overflow), .any_overflow(any_overflow),
    .wvb_wused(wvb_wused), .almost_full(almost_full), .ovf_sticky(ovf_sticky),
    .ovf_cnt(ovf_cnt), .wused_hwm(wused_hwm)
  );

  function automatic logic [15:0] wu(input int c);
    return wvb_wused[c*16 +: 16];
  endfunction
  function automatic logic [15:0] hw(input int c);
    return wused_hwm[c*16 +: 16];
  endfunction
  function automatic logic [C-1:0] cnt(input int c);
    return ovf_cnt[c*C +: C];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) exp_q.push_back(32'h0);
    tick();
    for (int c = 0; c < N; c++) begin
      e = exp_q.pop_front();
      checks++; if (32'(wu(c)) !== e) begin failures++; $display("FAIL reset_wused ch%0d got=%h exp=%h", c, wu(c), e); end
      checks++; if (32'(hw(c)) !== e) begin failures++; $display("FAIL reset_hwm ch%0d got=%h exp=%h", c, hw(c), e); end
      checks++; if (32'({ovf_sticky[c], almost_full[c], overflow[c], cnt(c)}) !== e) begin
        failures++; $display("FAIL reset_flags ch%0d got=%b%b%b cnt=%h exp=0", c, ovf_sticky[c], almost_full[c], overflow[c], cnt(c));
      end
    end
  endtask

  task automatic test_read_ramp();
    wvb_rddone[3] = 1'b1;
    stop[3] = 12'h0FF;
    tick();
    wvb_rddone[3] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      wr[3] = 12'h100 + 12'(k * 256);
      exp_q.push_back(32'(k * 256));
      tick();
      e = exp_q.pop_front();
      checks++; if (32'(wu(3)) !== e) begin failures++; $display("FAIL ramp_wused k=%0d got=%h exp=%h", k, wu(3), e); end
    end
    wr[3] = 12'h0FE;
    exp_q.push_back(32'hFFE);
    tick();
    e = exp_q.pop_front();
    checks++; if (32'(wu(3)) !== e) begin failures++; $display("FAIL ramp_wused_top got=%h exp=%h", wu(3), e); end
    wr[3] = 12'h0FF;
    #1;
    checks++; if ({overflow[3], any_overflow} !== 2'b11) begin failures++; $display("FAIL ramp_overflow got=%b%b exp=11", overflow[3], any_overflow); end
    exp_q.push_back(32'h11);
    exp_q.push_back(32'hFFF);
    tick();
    e = exp_q.pop_front();
    checks++; if (32'({ovf_sticky[3], cnt(3)}) !== e) begin failures++; $display("FAIL ramp_sticky_cnt got=%b/%h exp=1/1", ovf_sticky[3], cnt(3)); end
    e = exp_q.pop_front();
    checks++; if (32'(wu(3)) !== e) begin failures++; $display("FAIL ramp_wused_ovf got=%h exp=%h", wu(3), e); end
    for (int c = 0; c < 3; c++) begin
      checks++; if ({overflow[c], ovf_sticky[c], cnt(c), wu(c)} !== '0) begin
        failures++; $display("FAIL ramp_other ch%0d ovf=%b sticky=%b cnt=%h wused=%h exp=0", c, overflow[c], ovf_sticky[c], cnt(c), wu(c));
      end
    end
    wr[3] = 12'h0FE;
    tick();
  endtask

  task automatic test_full();
    wr[0] = 12'hFFF;
    #1;
    checks++; if (overflow[0] !== 1'b1) begin failures++; $display("FAIL full_overflow got=%b exp=1", overflow[0]); end
    tick();
    wr[0] = 12'h000;
    exp_q.push_back(32'h1000);
    exp_q.push_back(32'h1000);
    exp_q.push_back(32'h1000);
    exp_q.push_back(32'h0800);
    tick();
    e = exp_q.pop_front();
    checks++; if (32'(wu(0)) !== e) begin failures++; $display("FAIL full_set got=%h exp=%h", wu(0), e); end
    tick();
    e = exp_q.pop_front();
    checks++; if (32'(wu(0)) !== e) begin failures++; $display("FAIL full_hold got=%h exp=%h", wu(0), e); end
    wvb_rddone[0] = 1'b1;
    stop[0] = 12'h7FF;
    tick();
    wvb_rddone[0] = 1'b0;
    e = exp_q.pop_front();
    checks++; if (32'(wu(0)) !== e) begin failures++; $display("FAIL full_after_rddone1 got=%h exp=%h", wu(0), e); end
    tick();
    e = exp_q.pop_front();
    checks++; if (32'(wu(0)) !== e) begin failures++; $display("FAIL full_cleared got=%h exp=%h", wu(0), e); end
  endtask

  task automatic test_almost_full();
    logic [A-1:0] wv [5] = '{12'h7FF, 12'h800, 12'h500, 12'h400, 12'h3FF};
    logic         ev [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    thresh_hi = 16'h0800;
    thresh_lo = 16'h0400;
    for (int i = 0; i < 5; i++) begin
      wr[1] = wv[i];
      exp_q.push_back(32'(wv[i]));
      exp_q.push_back(32'(ev[i]));
      tick();
      e = exp_q.pop_front();
      checks++; if (32'(wu(1)) !== e) begin failures++; $display("FAIL af_wused step%0d got=%h exp=%h", i, wu(1), e); end
      tick();
      e = exp_q.pop_front();
      checks++; if (32'(almost_full[1]) !== e) begin failures++; $display("FAIL af_flag step%0d got=%b exp=%0d", i, almost_full[1], e); end
    end
  endtask

  task automatic test_cnt_saturate();
    for (int i = 0; i < 20; i++) begin
      hdr_full[2] = 1'b1;
      #1;
      checks++; if (overflow[2] !== 1'b1) begin failures++; $display("FAIL sat_overflow pulse%0d got=%b exp=1", i, overflow[2]); end
      tick();
      hdr_full[2] = 1'b0;
      tick();
    end
    exp_q.push_back(32'h1F);
    e = exp_q.pop_front();
    checks++; if (32'({ovf_sticky[2], cnt(2)}) !== e) begin failures++; $display("FAIL sat_cnt got=%b/%h exp=1/F", ovf_sticky[2], cnt(2)); end
    hdr_full[2] = 1'b1;
    ovf_clr[2] = 1'b1;
    exp_q.push_back(32'h11);
    tick();
    hdr_full[2] = 1'b0;
    ovf_clr[2] = 1'b0;
    e = exp_q.pop_front();
    checks++; if (32'({ovf_sticky[2], cnt(2)}) !== e) begin failures++; $display("FAIL clr_with_edge got=%b/%h exp=1/1", ovf_sticky[2], cnt(2)); end
    tick();
    ovf_clr[2] = 1'b1;
    exp_q.push_back(32'h00);
    tick();
    ovf_clr[2] = 1'b0;
    e = exp_q.pop_front();
    checks++; if (32'({ovf_sticky[2], cnt(2)}) !== e) begin failures++; $display("FAIL clr_alone got=%b/%h exp=0/0", ovf_sticky[2], cnt(2)); end
  endtask

  task automatic test_hwm_and_reset();
    logic [A-1:0] rv [4] = '{12'h300, 12'h600, 12'h900, 12'h100};
    for (int i = 0; i < 4; i++) begin
      wr[2] = rv[i];
      tick();
    end
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h900);
    exp_q.push_back(32'h100);
    tick();
    tick();
    e = exp_q.pop_front();
    checks++; if (32'(wu(2)) !== e) begin failures++; $display("FAIL hwm_wused got=%h exp=%h", wu(2), e); end
    e = exp_q.pop_front();
    checks++; if (32'(hw(2)) !== e) begin failures++; $display("FAIL hwm_peak got=%h exp=%h", hw(2), e); end
    hwm_clr[2] = 1'b1;
    tick();
    hwm_clr[2] = 1'b0;
    e = exp_q.pop_front();
    checks++; if (32'(hw(2)) !== e) begin failures++; $display("FAIL hwm_clr got=%h exp=%h", hw(2), e); end
    wr[2] = 12'h500;
    tick();
    tick();
    rst_n = 1'b0;
    wvb_rddone = '1;
    hdr_full = '1;
    ovf_clr = '1;
    for (int c = 0; c < N; c++) exp_q.push_back(32'h0);
    tick();
    for (int c = 0; c < N; c++) begin
      e = exp_q.pop_front();
      checks++; if (32'({wu(c), hw(c)}) !== e) begin failures++; $display("FAIL midrst_wused_hwm ch%0d got=%h/%h exp=0", c, wu(c), hw(c)); end
      checks++; if (32'({ovf_sticky[c], almost_full[c], cnt(c)}) !== e) begin
        failures++; $display("FAIL midrst_flags ch%0d sticky=%b af=%b cnt=%h exp=0", c, ovf_sticky[c], almost_full[c], cnt(c));
      end
    end
    rst_n = 1'b1;
    wvb_rddone = '0;
    hdr_full = '0;
    ovf_clr = '0;
    exp_q.push_back(32'h500);
    tick();
    e = exp_q.pop_front();
    checks++; if (32'(wu(2)) !== e) begin failures++; $display("FAIL postrst_wused got=%h exp=%h", wu(2), e); end
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      wr[c] = '0;
      stop[c] = '0;
    end
    test_reset();
    test_read_ramp();
    test_full();
    test_almost_full();
    test_cnt_saturate();
    test_hwm_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
